// File: rtl/tcb_lib_multiplexer.sv
// Arbitrated N-to-1 TCB multiplexer: several managers share one subordinate port.
// Grant is locked across back-pressure and responses are routed back after DLY cycles.
module tcb_lib_multiplexer #(
    parameter int unsigned IFN  = 2,
    parameter int unsigned DLY  = 1,
    parameter string       ARB  = "RR",
    parameter int unsigned REQW = 64,
    parameter int unsigned RSPW = 33,
    localparam int unsigned IFL = $clog2(IFN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IFN-1:0]            sub_vld,
    input  logic [IFN-1:0][REQW-1:0]  sub_req,
    output logic [IFN-1:0]            sub_rdy,
    output logic [IFN-1:0][RSPW-1:0]  sub_rsp,
    output logic                      man_vld,
    output logic [REQW-1:0]           man_req,
    input  logic                      man_rdy,
    input  logic [RSPW-1:0]           man_rsp,
    output logic [IFL-1:0]            gnt,
    output logic                      lck
);

    localparam bit USE_FIX = (ARB == "FIX");

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [IFL-1:0]  ptr, ptr_nxt, lck_idx, arb_gnt;
    logic            found, trn;
    int unsigned     scan;

    // Circular scan from ptr (RR) or from 0 (FIX); the wrap is an explicit compare.
    always_comb begin
        arb_gnt = USE_FIX ? '0 : ptr;
        found   = 1'b0;
        scan    = 0;
        for (int unsigned k = 0; k < IFN; k++) begin
            scan = USE_FIX ? k : 32'(ptr) + k;
            if (scan >= IFN) scan = scan - IFN;
            if (!found && sub_vld[IFL'(scan)]) begin
                found   = 1'b1;
                arb_gnt = IFL'(scan);
            end
        end
    end

    always_comb begin
        gnt     = rst ? '0 : ((state == LOCKED) ? lck_idx : arb_gnt);
        lck     = (state == LOCKED) && !rst;
        man_vld = sub_vld[gnt];
        man_req = sub_req[gnt];
        trn     = man_vld && man_rdy;
        sub_rdy = '0;
        sub_rdy[gnt] = man_rdy;
        ptr_nxt = (32'(gnt) == IFN - 1) ? '0 : gnt + 1'b1;
        state_nxt = state;
        case (state)
            IDLE:    if (man_vld && !man_rdy) state_nxt = LOCKED;
            LOCKED:  if (trn) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            lck_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == LOCKED) lck_idx <= gnt;
            if (trn) ptr <= ptr_nxt;
        end
    end

    generate
        if (DLY == 0) begin : g_direct
            always_comb begin
                sub_rsp = '0;
                if (trn) sub_rsp[gnt] = man_rsp;
            end
        end else begin : g_pipe
            logic [DLY-1:0][IFL-1:0] idx_p;
            logic [DLY-1:0]          vld_p;

            // One entry per stage, so back-to-back transfers never collide.
            always_ff @(posedge clk) begin
                if (rst) begin
                    idx_p <= '0;
                    vld_p <= '0;
                end else begin
                    idx_p[0] <= gnt;
                    vld_p[0] <= trn;
                    for (int unsigned s = 1; s < DLY; s++) begin
                        idx_p[s] <= idx_p[s-1];
                        vld_p[s] <= vld_p[s-1];
                    end
                end
            end

            always_comb begin
                sub_rsp = '0;
                if (vld_p[DLY-1]) sub_rsp[idx_p[DLY-1]] = man_rsp;
            end
        end
    endgenerate

endmodule

// File: tb/tb_tcb_lib_multiplexer.sv
// Self-checking bench: three multiplexer configurations share stimulus and are
// compared every cycle against a transaction-level reference model.
module tb_tcb_lib_multiplexer;

    localparam int N = 3;
    localparam int W = 16;

    typedef struct {
        int k;
        int idx;
        int due;
    } pend_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         sub_vld;
    logic [N-1:0][W-1:0]  sub_req;
    logic                 man_rdy;
    logic [W-1:0]         man_rsp;

    logic [N-1:0]         sub_rdy_k [3];
    logic [N-1:0][W-1:0]  sub_rsp_k [3];
    logic                 man_vld_k [3];
    logic [W-1:0]         man_req_k [3];
    logic [1:0]           gnt_k     [3];
    logic                 lck_k     [3];

    int dly_k [3] = '{1, 2, 0};
    bit fix_k [3] = '{1'b0, 1'b0, 1'b1};

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    m_ptr  [3] = '{0, 0, 0};
    bit    m_lock [3] = '{1'b0, 1'b0, 1'b0};
    int    m_lidx [3] = '{0, 0, 0};
    pend_t pend [$];
    int    obs_gnt [3];
    bit    obs_lck [3];

    always #5 clk = ~clk;

    tcb_lib_multiplexer #(.IFN(N), .DLY(1), .ARB("RR"), .REQW(W), .RSPW(W)) u_rr1 (
        .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_req(sub_req), .sub_rdy(sub_rdy_k[0]),
        .sub_rsp(sub_rsp_k[0]), .man_vld(man_vld_k[0]), .man_req(man_req_k[0]),
        .man_rdy(man_rdy), .man_rsp(man_rsp), .gnt(gnt_k[0]), .lck(lck_k[0]));

    tcb_lib_multiplexer #(.IFN(N), .DLY(2), .ARB("RR"), .REQW(W), .RSPW(W)) u_rr2 (
        .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_req(sub_req), .sub_rdy(sub_rdy_k[1]),
        .sub_rsp(sub_rsp_k[1]), .man_vld(man_vld_k[1]), .man_req(man_req_k[1]),
        .man_rdy(man_rdy), .man_rsp(man_rsp), .gnt(gnt_k[1]), .lck(lck_k[1]));

    tcb_lib_multiplexer #(.IFN(N), .DLY(0), .ARB("FIX"), .REQW(W), .RSPW(W)) u_fix0 (
        .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_req(sub_req), .sub_rdy(sub_rdy_k[2]),
        .sub_rsp(sub_rsp_k[2]), .man_vld(man_vld_k[2]), .man_req(man_req_k[2]),
        .man_rdy(man_rdy), .man_rsp(man_rsp), .gnt(gnt_k[2]), .lck(lck_k[2]));

    task automatic chk(input string tag, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", tag, k, cyc, got, exp);
        end
    endtask

    // First requesting manager in priority order; idle grant is the priority start.
    function automatic int pick(input int k);
        int i;
        for (int o = 0; o < N; o++) begin
            i = fix_k[k] ? o : (m_ptr[k] + o) % N;
            if (sub_vld[i]) return i;
        end
        return fix_k[k] ? 0 : m_ptr[k];
    endfunction

    task automatic step();
        logic [N-1:0][W-1:0] ersp;
        pend_t               keep [$];
        int                  g;
        bit                  v;
        bit                  t;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rst)            g = 0;
            else if (m_lock[k]) g = m_lidx[k];
            else                g = pick(k);
            v = sub_vld[g];
            t = v && man_rdy;
            chk("gnt", k, 64'(gnt_k[k]), 64'(g));
            chk("lck", k, 64'(lck_k[k]), 64'(m_lock[k] && !rst));
            chk("man_vld", k, 64'(man_vld_k[k]), 64'(v));
            chk("man_req", k, 64'(man_req_k[k]), 64'(sub_req[g]));
            chk("sub_rdy", k, 64'(sub_rdy_k[k]), man_rdy ? (64'd1 << g) : 64'd0);
            ersp = '0;
            if (dly_k[k] == 0 && t) ersp[g] = man_rsp;
            foreach (pend[p]) if (pend[p].k == k && pend[p].due == cyc) ersp[pend[p].idx] = man_rsp;
            chk("sub_rsp", k, 64'(sub_rsp_k[k]), 64'(ersp));
            obs_gnt[k] = int'(gnt_k[k]);
            obs_lck[k] = lck_k[k];
            if (!rst) begin
                if (!m_lock[k] && v && !man_rdy) begin
                    m_lock[k] = 1'b1;
                    m_lidx[k] = g;
                end else if (m_lock[k] && t) begin
                    m_lock[k] = 1'b0;
                end
                if (t) begin
                    m_ptr[k] = (g + 1) % N;
                    if (dly_k[k] > 0) pend.push_back('{k, g, cyc + dly_k[k]});
                end
            end
        end
        if (rst) begin
            pend.delete();
            for (int k = 0; k < 3; k++) begin
                m_ptr[k] = 0;
                m_lock[k] = 1'b0;
                m_lidx[k] = 0;
            end
        end else begin
            foreach (pend[p]) if (pend[p].due > cyc) keep.push_back(pend[p]);
            pend = keep;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sub_vld = '0;
        sub_req = '0;
        man_rdy = 1'b0;
        man_rsp = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // single manager write to 0x10, immediate rdy
        sub_vld = 3'b010;
        sub_req[1] = 16'h8010;
        man_rdy = 1'b1;
        man_rsp = 16'hA5A5;
        step();
        chk("single_gnt", 0, 64'(obs_gnt[0]), 64'd1);
        sub_vld = '0;
        man_rsp = 16'h1234;
        step();
        man_rsp = 16'h5678;
        step();

        // round-robin fairness with all managers requesting
        reset_pulse();
        sub_vld = 3'b111;
        man_rdy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            man_rsp = W'($urandom);
            step();
            chk("rr_order", 0, 64'(obs_gnt[0]), 64'(j % N));
            chk("fix_starve", 2, 64'(obs_gnt[2]), 64'd0);
        end

        // back-pressure lock on manager 2 while manager 0 requests
        sub_vld = '0;
        reset_pulse();
        sub_vld = 3'b100;
        man_rdy = 1'b0;
        step();
        sub_vld = 3'b101;
        step();
        step();
        chk("bp_gnt", 0, 64'(obs_gnt[0]), 64'd2);
        chk("bp_lck", 0, 64'(obs_lck[0]), 64'd1);
        man_rdy = 1'b1;
        step();
        chk("bp_trn_gnt", 0, 64'(obs_gnt[0]), 64'd2);
        sub_vld = 3'b001;
        step();
        chk("bp_next_gnt", 0, 64'(obs_gnt[0]), 64'd0);

        // back-to-back transfers 1 then 0, responses through the pipeline
        sub_vld = '0;
        reset_pulse();
        man_rdy = 1'b1;
        sub_vld = 3'b010;
        sub_req[1] = 16'h0011;
        man_rsp = 16'h1111;
        step();
        sub_vld = 3'b001;
        sub_req[0] = 16'h0022;
        man_rsp = 16'h2222;
        step();
        sub_vld = '0;
        for (int j = 0; j < 3; j++) begin
            man_rsp = W'(16'h3000 + j);
            step();
        end

        // reset while locked with a response in flight
        sub_vld = 3'b010;
        man_rdy = 1'b1;
        step();
        sub_vld = 3'b100;
        man_rdy = 1'b0;
        step();
        rst = 1'b1;
        man_rsp = 16'hBEEF;
        step();
        rst = 1'b0;
        sub_vld = '0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("rst_lck", 1, 64'(obs_lck[1]), 64'd0);
            chk("rst_rsp", 1, 64'(sub_rsp_k[1]), 64'd0);
        end

        // randomized traffic with occasional resets
        for (int j = 0; j < 1500; j++) begin
            sub_vld = N'($urandom);
            for (int i = 0; i < N; i++) sub_req[i] = W'($urandom);
            man_rdy = ($urandom_range(0, 3) != 0);
            man_rsp = W'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
